mau_bus_driver: RTL and testbench
=================================

Name: mau_bus_driver

Overview:
- Initiator side of the Matrix Acceleration Unit (MAU) bus protocol.
- Accepts one vector job from the GPU command path: up to four FP16 operands, mode and add_mode.
- Pulses start, drives the operands onto data_bus_supr/data_bus_infr in the cycles the MAU samples them, waits for busy to drop, then pulses read_output and captures the FP16 result(s) back off the shared buses.
- Returns results through a valid/ready response port.

Parameters:
- PRIMARY_OUTPUT, "dbs", bus ("dbs" or "dbi") that carries the single result in mode 0; must match the paired MAU.
- BUSY_TIMEOUT, 31, max cycles to wait for busy low before abort; used only with the optional feature; range 8..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  job request valid
- req_ready  out  1  driver can accept a job (high only in IDLE)
- req_mode  in  1  MAU mode (1 = n*2 two results, 0 = n*3/n*4 one result)
- req_add_mode  in  1  MAU add_mode
- req_operands  in  64  FP16 x3..x0; x0 at [15:0]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_result  out  32  [15:0] = result0, [31:16] = result1 (0 in mode 0)
- rsp_error  out  1  busy timeout (optional feature only; otherwise tied 0)
- mau_start  out  1  MAU start pulse
- mau_mode  out  1  registered req_mode
- mau_add_mode  out  1  registered req_add_mode
- mau_read_output  out  1  MAU result-drive enable
- mau_busy  in  1  MAU busy
- data_bus_supr  inout  16  shared superior bus
- data_bus_infr  inout  16  shared inferior bus

Behaviour:
- Reset, synchronous: state = IDLE, all outputs 0, both buses released to 'z, operand/result registers cleared.
- Reset asserted mid-job aborts immediately, with no response issued. The MAU must be reset together with this block.
- States: IDLE, START, OPA, HOLD1, HOLD2, OPB, WAIT, READ, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid, latch operands, mode and add_mode, then go to START.
- START (T0): mau_start = 1 for exactly this cycle, then go to OPA.
- OPA (T1): drive supr = x0 and infr = x1, then go to HOLD1.
- HOLD1 (T2): drive infr = x1 (MAU reuses the buffered copy; driving is harmless). supr = z. Go to HOLD2.
- HOLD2 (T3): both buses z. Go to OPB.
- OPB (T4)
  - mode 0: drive supr = x2, infr = x3.
  - mode 1 with add_mode 1: drive infr = x3, supr = z.
  - mode 1 with add_mode 0: both buses z.
  - Go to WAIT.
- WAIT
  - Both buses z.
  - When mau_busy = 0, go to READ. busy is sampled only from WAIT onward, because busy is legitimately 0 at T0.
- READ
  - mau_read_output = 1 for one cycle. This block drives nothing.
  - Capture the buses at the clock edge:
    - mode 1: result0 = supr, result1 = infr.
    - mode 0: result0 = the PRIMARY_OUTPUT bus, result1 = 0.
  - Go to RESP.
- RESP
  - rsp_valid = 1 with stable rsp_result.
  - On rsp_ready, go to IDLE. Back-pressure holds RESP indefinitely.
- Minimum job latency: req accept to rsp_valid = 6 cycles + WAIT duration.
- Bus contention rule: this block never drives a bus in READ or WAIT, or in any cycle where mau_read_output = 1. Asserted by an internal check in simulation.
- req_valid outside IDLE is ignored (req_ready = 0). No queuing.
- mau_mode and mau_add_mode are held constant from START through READ.

Optional Feature:
- Macro: MAU_DRV_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in WAIT.
  - If busy is still 1 after BUSY_TIMEOUT cycles, skip READ and go to RESP with rsp_error = 1 and rsp_result = 0.
  - rsp_error clears on leaving RESP.
- Undefined: no counter, WAIT is unbounded, rsp_error is constant 0.

Test Plan:
- Mode 0, add_mode 0, x0..x3 = 3C00,4000,4200,4400, PRIMARY_OUTPUT "dbs", MAU model drops busy 10 cycles after T1 and drives supr = 4A00 → supr = 3C00 and infr = 4000 at T1; supr = 4200 and infr = 4400 at T4; read_output pulse of 1 cycle; rsp_result = 0000_4A00.
- Mode 1, add_mode 0, model drives supr = 3E00, infr = 4100 on read → OPB drives nothing; rsp_result = 4100_3E00.
- Mode 1, add_mode 1 → infr = x3 at T4 and supr = z; results captured as above.
- rsp_ready held low 5 cycles, then req_valid asserted during RESP → rsp_valid and rsp_result stable; req_ready = 0; second job starts only after the handshake.
- Reset pulsed in OPB → next cycle both buses z, mau_start = 0, state IDLE, rsp_valid = 0.
- With MAU_DRV_TIMEOUT_EN and BUSY_TIMEOUT = 8, busy stuck high → read_output never asserted; rsp_valid with rsp_error = 1 and result 0.

Source files
------------

// File: rtl/mau_bus_driver.sv
// Initiator side of the MAU bus: sequences one vector job over the shared buses and returns the result.
// Optional busy-timeout abort is compiled in with `define MAU_DRV_TIMEOUT_EN.
module mau_bus_driver #(
  parameter string       PRIMARY_OUTPUT = "dbs",
  parameter int unsigned BUSY_TIMEOUT   = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic        req_add_mode,
  input  logic [63:0] req_operands,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic        mau_start,
  output logic        mau_mode,
  output logic        mau_add_mode,
  output logic        mau_read_output,
  input  logic        mau_busy,
  inout  wire  [15:0] data_bus_supr,
  inout  wire  [15:0] data_bus_infr
);

  localparam int unsigned W    = 16;
  localparam int unsigned OPW  = 4 * W;
  localparam int unsigned RESW = 2 * W;
  localparam bit          PRI_INFR = (PRIMARY_OUTPUT == "dbi");

  typedef enum logic [3:0] {
    IDLE, START, OPA, HOLD1, HOLD2, OPB, WAIT, READ, RESP
  } state_e;

  state_e           state_q, state_d;
  logic [OPW-1:0]   ops_q, ops_d;
  logic             mode_q, mode_d;
  logic             add_q, add_d;
  logic [RESW-1:0]  result_q, result_d;
  logic             start_q, start_d;
  logic             rd_q, rd_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             supr_oe_q, supr_oe_d;
  logic             infr_oe_q, infr_oe_d;
  logic [W-1:0]     supr_out_q, supr_out_d;
  logic [W-1:0]     infr_out_q, infr_out_d;
  logic             timeout_c;
`ifdef MAU_DRV_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next state, job latching and result capture; outputs are decoded from state_d so they register cleanly.
  always_comb begin
    state_d    = state_q;
    ops_d      = ops_q;
    mode_d     = mode_q;
    add_d      = add_q;
    result_d   = result_q;
    timeout_c  = 1'b0;
`ifdef MAU_DRV_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_ready_q && req_valid) begin
          ops_d   = req_operands;
          mode_d  = req_mode;
          add_d   = req_add_mode;
          state_d = START;
        end
      end
      START: state_d = OPA;
      OPA:   state_d = HOLD1;
      HOLD1: state_d = HOLD2;
      HOLD2: state_d = OPB;
      OPB: begin
        state_d = WAIT;
`ifdef MAU_DRV_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      WAIT: begin
        if (!mau_busy) begin
          state_d = READ;
        end
`ifdef MAU_DRV_TIMEOUT_EN
        else if (cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          result_d  = '0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      READ: begin
        if (mode_q) result_d = {data_bus_infr, data_bus_supr};
        else        result_d = {{W{1'b0}}, (PRI_INFR ? data_bus_infr : data_bus_supr)};
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_d     = (state_d == START);
    rd_d        = (state_d == READ);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);

    supr_oe_d  = 1'b0;
    infr_oe_d  = 1'b0;
    supr_out_d = '0;
    infr_out_d = '0;
    case (state_d)
      OPA: begin
        supr_oe_d  = 1'b1;
        supr_out_d = ops_d[0*W +: W];
        infr_oe_d  = 1'b1;
        infr_out_d = ops_d[1*W +: W];
      end
      HOLD1: begin
        infr_oe_d  = 1'b1;
        infr_out_d = ops_d[1*W +: W];
      end
      OPB: begin
        if (!mode_d) begin
          supr_oe_d  = 1'b1;
          supr_out_d = ops_d[2*W +: W];
          infr_oe_d  = 1'b1;
          infr_out_d = ops_d[3*W +: W];
        end else if (add_d) begin
          infr_oe_d  = 1'b1;
          infr_out_d = ops_d[3*W +: W];
        end
      end
      default: ;
    endcase

`ifdef MAU_DRV_TIMEOUT_EN
    err_d = timeout_c | ((state_d == RESP) & err_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ops_q       <= '0;
      mode_q      <= 1'b0;
      add_q       <= 1'b0;
      result_q    <= '0;
      start_q     <= 1'b0;
      rd_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      supr_oe_q   <= 1'b0;
      infr_oe_q   <= 1'b0;
      supr_out_q  <= '0;
      infr_out_q  <= '0;
`ifdef MAU_DRV_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ops_q       <= ops_d;
      mode_q      <= mode_d;
      add_q       <= add_d;
      result_q    <= result_d;
      start_q     <= start_d;
      rd_q        <= rd_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      supr_oe_q   <= supr_oe_d;
      infr_oe_q   <= infr_oe_d;
      supr_out_q  <= supr_out_d;
      infr_out_q  <= infr_out_d;
`ifdef MAU_DRV_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign data_bus_supr   = supr_oe_q ? supr_out_q : {W{1'bz}};
  assign data_bus_infr   = infr_oe_q ? infr_out_q : {W{1'bz}};
  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = result_q;
  assign mau_start       = start_q;
  assign mau_mode        = mode_q;
  assign mau_add_mode    = add_q;
  assign mau_read_output = rd_q;
`ifdef MAU_DRV_TIMEOUT_EN
  assign rsp_error       = err_q;
`else
  assign rsp_error       = 1'b0;
`endif

  // The MAU owns both buses whenever it may be driving results.
  assert property (@(posedge clk) disable iff (reset)
    !((supr_oe_q || infr_oe_q) && (state_q == WAIT || state_q == READ || rd_q)));
  assert property (@(posedge clk) (BUSY_TIMEOUT >= 8) && (BUSY_TIMEOUT <= 255));

endmodule

// File: tb/tb_mau_bus_driver.sv
// Directed bench for mau_bus_driver with a small behavioural MAU on the shared buses.
// Define MAU_DRV_TIMEOUT_EN to also exercise the busy-timeout abort.
module tb_mau_bus_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mode = 1'b0;
  logic        req_add_mode = 1'b0;
  logic [63:0] req_operands = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_error;
  logic        mau_start;
  logic        mau_mode;
  logic        mau_add_mode;
  logic        mau_read_output;
  logic        busy = 1'b0;
  wire  [15:0] dbs;
  wire  [15:0] dbi;

  int          busy_len = 4;
  int          bcnt = 0;
  bit          stuck = 1'b0;
  logic [15:0] mdl_supr = '0;
  logic [15:0] mdl_infr = '0;

  int          n_checks = 0;
  int          n_fail = 0;

  mau_bus_driver #(.PRIMARY_OUTPUT("dbs"), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_add_mode(req_add_mode), .req_operands(req_operands),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .mau_start(mau_start), .mau_mode(mau_mode),
    .mau_add_mode(mau_add_mode), .mau_read_output(mau_read_output),
    .mau_busy(busy), .data_bus_supr(dbs), .data_bus_infr(dbi)
  );

  always #5 clk = ~clk;

  // Behavioural MAU: busy from the cycle after start for busy_len cycles, results driven on read_output.
  assign dbs = mau_read_output ? mdl_supr : 16'bz;
  assign dbi = mau_read_output ? mdl_infr : 16'bz;

  always @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      bcnt <= 0;
    end else if (mau_start) begin
      busy <= 1'b1;
      bcnt <= busy_len;
    end else if (busy && !stuck) begin
      if (bcnt <= 1) busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mau_start !== 1'b0 || mau_read_output !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b start=%b rd=%b want all 0",
               req_ready, rsp_valid, mau_start, mau_read_output);
    end
    n_checks++;
    if (mau_mode !== 1'b0 || mau_add_mode !== 1'b0 || rsp_result !== 32'h0 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got mode=%b add=%b result=%h err=%b want 0,0,00000000,0",
               mau_mode, mau_add_mode, rsp_result, rsp_error);
    end
    n_checks++;
    if (!released(dbs) || !released(dbi)) begin
      n_fail++;
      $display("FAIL reset_bus: got supr=%h infr=%h want released", dbs, dbi);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got ready=%b valid=%b want 1,0", req_ready, rsp_valid);
    end
  endtask

  // Accepts a job and checks T0..T4 bus activity; returns positioned in OPB.
  task automatic test_operand_phase(input logic mode, input logic add, input logic [63:0] ops);
    req_mode = mode;
    req_add_mode = add;
    req_operands = ops;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n_checks++;
    if (mau_start !== 1'b1 || req_ready !== 1'b0 || mau_mode !== mode || mau_add_mode !== add) begin
      n_fail++;
      $display("FAIL t0_start: got start=%b ready=%b mode=%b add=%b want 1,0,%b,%b",
               mau_start, req_ready, mau_mode, mau_add_mode, mode, add);
    end
    step();
    n_checks++;
    if (dbs !== ops[15:0] || dbi !== ops[31:16] || mau_start !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_opa: got supr=%h infr=%h start=%b want %h,%h,0",
               dbs, dbi, mau_start, ops[15:0], ops[31:16]);
    end
    step();
    n_checks++;
    if (!released(dbs) || dbi !== ops[31:16]) begin
      n_fail++;
      $display("FAIL t2_hold1: got supr=%h infr=%h want released,%h", dbs, dbi, ops[31:16]);
    end
    step();
    n_checks++;
    if (!released(dbs) || !released(dbi)) begin
      n_fail++;
      $display("FAIL t3_hold2: got supr=%h infr=%h want released", dbs, dbi);
    end
    step();
    n_checks++;
    if (!mode) begin
      if (dbs !== ops[47:32] || dbi !== ops[63:48]) begin
        n_fail++;
        $display("FAIL t4_opb_m0: got supr=%h infr=%h want %h,%h", dbs, dbi, ops[47:32], ops[63:48]);
      end
    end else if (add) begin
      if (!released(dbs) || dbi !== ops[63:48]) begin
        n_fail++;
        $display("FAIL t4_opb_m1a1: got supr=%h infr=%h want released,%h", dbs, dbi, ops[63:48]);
      end
    end else begin
      if (!released(dbs) || !released(dbi)) begin
        n_fail++;
        $display("FAIL t4_opb_m1a0: got supr=%h infr=%h want released", dbs, dbi);
      end
    end
  endtask

  task automatic wait_resp(output int steps, output int reads, output logic mode_rd, output logic add_rd);
    steps = 0;
    reads = 0;
    mode_rd = 1'bx;
    add_rd = 1'bx;
    while (rsp_valid !== 1'b1 && steps < 60) begin
      step();
      steps++;
      if (mau_read_output === 1'b1) begin
        reads++;
        mode_rd = mau_mode;
        add_rd = mau_add_mode;
      end
    end
  endtask

  task automatic test_mode0();
    int steps, reads;
    logic m, a;
    busy_len = 10;
    mdl_supr = 16'h4A00;
    mdl_infr = 16'h1357;
    rsp_ready = 1'b1;
    test_operand_phase(1'b0, 1'b0, 64'h4400_4200_4000_3C00);
    wait_resp(steps, reads, m, a);
    n_checks++;
    if (steps !== 9 || reads !== 1 || m !== 1'b0) begin
      n_fail++;
      $display("FAIL m0_timing: got steps=%0d reads=%0d mode_rd=%b want 9,1,0", steps, reads, m);
    end
    n_checks++;
    if (rsp_result !== 32'h0000_4A00 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL m0_result: got %h err=%b want 00004a00,0", rsp_result, rsp_error);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL m0_idle: got valid=%b ready=%b want 0,1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_mode1_add0();
    int steps, reads;
    logic m, a;
    busy_len = 4;
    mdl_supr = 16'h3E00;
    mdl_infr = 16'h4100;
    rsp_ready = 1'b1;
    test_operand_phase(1'b1, 1'b0, 64'h4800_4600_4500_4300);
    wait_resp(steps, reads, m, a);
    n_checks++;
    if (steps !== 3 || reads !== 1 || m !== 1'b1 || a !== 1'b0) begin
      n_fail++;
      $display("FAIL m1a0_timing: got steps=%0d reads=%0d mode=%b add=%b want 3,1,1,0", steps, reads, m, a);
    end
    n_checks++;
    if (rsp_result !== 32'h4100_3E00) begin
      n_fail++;
      $display("FAIL m1a0_result: got %h want 41003e00", rsp_result);
    end
    step();
  endtask

  task automatic test_mode1_add1();
    int steps, reads;
    logic m, a;
    busy_len = 6;
    mdl_supr = 16'h5000;
    mdl_infr = 16'h5100;
    rsp_ready = 1'b1;
    test_operand_phase(1'b1, 1'b1, 64'h4C00_4B00_4A00_4900);
    wait_resp(steps, reads, m, a);
    n_checks++;
    if (steps !== 5 || reads !== 1 || m !== 1'b1 || a !== 1'b1) begin
      n_fail++;
      $display("FAIL m1a1_timing: got steps=%0d reads=%0d mode=%b add=%b want 5,1,1,1", steps, reads, m, a);
    end
    n_checks++;
    if (rsp_result !== 32'h5100_5000 || rsp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL m1a1_result: got %h err=%b want 51005000,0", rsp_result, rsp_error);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int steps, reads;
    logic m, a;
    busy_len = 4;
    mdl_supr = 16'h2222;
    mdl_infr = 16'h1111;
    rsp_ready = 1'b0;
    test_operand_phase(1'b1, 1'b0, 64'h4700_4600_4500_4400);
    wait_resp(steps, reads, m, a);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL b2b_first: got valid=%b result=%h want 1,11112222", rsp_valid, rsp_result);
    end
    mdl_supr = 16'h5A5A;
    mdl_infr = 16'hA5A5;
    req_mode = 1'b0;
    req_add_mode = 1'b0;
    req_operands = 64'h3800_3900_3A00_3B00;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h1111_2222 || req_ready !== 1'b0 || mau_start !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold%0d: got valid=%b result=%h ready=%b start=%b want 1,11112222,0,0",
                 i, rsp_valid, rsp_result, req_ready, mau_start);
      end
    end
    rsp_ready = 1'b1;
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mau_start !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_handshake: got valid=%b ready=%b start=%b want 0,1,0", rsp_valid, req_ready, mau_start);
    end
    step();
    req_valid = 1'b0;
    n_checks++;
    if (mau_start !== 1'b1 || mau_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_start: got start=%b mode=%b want 1,0", mau_start, mau_mode);
    end
    for (int i = 0; i < 4; i++) step();
    wait_resp(steps, reads, m, a);
    n_checks++;
    if (steps !== 3 || reads !== 1 || rsp_result !== 32'h0000_5A5A) begin
      n_fail++;
      $display("FAIL b2b_second_result: got steps=%0d reads=%0d result=%h want 3,1,00005a5a",
               steps, reads, rsp_result);
    end
    step();
  endtask

`ifdef MAU_DRV_TIMEOUT_EN
  task automatic test_timeout();
    int steps, reads;
    logic m, a;
    stuck = 1'b1;
    busy_len = 4;
    rsp_ready = 1'b0;
    test_operand_phase(1'b1, 1'b0, 64'h4300_4200_4100_4000);
    wait_resp(steps, reads, m, a);
    n_checks++;
    if (steps !== 9 || reads !== 0) begin
      n_fail++;
      $display("FAIL to_timing: got steps=%0d reads=%0d want 9,0", steps, reads);
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_result !== 32'h0) begin
      n_fail++;
      $display("FAIL to_resp: got valid=%b err=%b result=%h want 1,1,00000000", rsp_valid, rsp_error, rsp_result);
    end
    step();
    n_checks++;
    if (rsp_error !== 1'b1 || mau_read_output !== 1'b0) begin
      n_fail++;
      $display("FAIL to_hold: got err=%b rd=%b want 1,0", rsp_error, mau_read_output);
    end
    rsp_ready = 1'b1;
    step();
    n_checks++;
    if (rsp_error !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear: got err=%b valid=%b want 0,0", rsp_error, rsp_valid);
    end
    stuck = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    bit leaked;
    busy_len = 10;
    rsp_ready = 1'b1;
    test_operand_phase(1'b0, 1'b0, 64'h4400_4200_4000_3C00);
    reset = 1'b1;
    step();
    n_checks++;
    if (!released(dbs) || !released(dbi) || mau_start !== 1'b0 || rsp_valid !== 1'b0 || mau_read_output !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_abort: got supr=%h infr=%h start=%b valid=%b rd=%b want released,released,0,0,0",
               dbs, dbi, mau_start, rsp_valid, mau_read_output);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_idle: got ready=%b want 1", req_ready);
    end
    leaked = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid !== 1'b0 || mau_read_output !== 1'b0 || mau_start !== 1'b0) leaked = 1'b1;
    end
    n_checks++;
    if (leaked) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got activity after abort want none");
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1_add0();
    test_mode1_add1();
    test_back_to_back();
`ifdef MAU_DRV_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
